mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the instruction-fetch port and the LSU data port onto the single unified memory port (`rom_sim`-style RAM) of the rv64 core. Sits between `fetch`/`lsu` and memory and replaces their direct wiring. Uses a req/gnt/rvalid handshake with at most one outstanding transaction. Data has priority, and an optional starvation guard bounds how long fetch can be locked out.

## Interface
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: memory data width; fetch returns 32 bits.
- `STARVE_MAX`, 4: consecutive denied fetch cycles before fetch is forced to win (guard only).
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `if_req_i` in 1: fetch request; held with `if_addr_i` until granted.
- `if_addr_i` in ADDR_W: fetch address; bit 2 selects the 32-bit half.
- `if_gnt_o` out 1: fetch request accepted this cycle.
- `if_rvalid_o` out 1: fetch response valid.
- `if_rdata_o` out 32: instruction word.
- `d_req_i` in 1: data request; held with all `d_*` inputs until granted.
- `d_we_i` in 1: write.
- `d_be_i` in 8: byte enables.
- `d_addr_i` in ADDR_W: data address.
- `d_wdata_i` in DATA_W: store data.
- `d_gnt_o` out 1: data request accepted.
- `d_rvalid_o` out 1: data response valid; pulses for writes too.
- `d_rdata_o` out DATA_W: load data.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: memory write.
- `mem_be_o` out 8: memory byte enables.
- `mem_addr_o` out ADDR_W: memory address.
- `mem_wdata_o` out DATA_W: memory write data.
- `mem_gnt_i` in 1: memory accepts the request (wait states allowed).
- `mem_rvalid_i` in 1: memory response, for both reads and writes.
- `mem_rdata_i` in DATA_W: memory read data.
- `busy_o` out 1: a transaction is outstanding.

## Operation
**States**
- IDLE: nothing outstanding.
- OUT_IF: fetch transaction outstanding.
- OUT_D: data transaction outstanding.

**Arbitration**
- Arbitration runs when the arbiter is free: state IDLE, or `mem_rvalid_i`=1 in an OUT state (back-to-back issue).
- Winner selection:
  - data wins if `d_req_i`;
  - otherwise fetch wins if `if_req_i`;
  - guard override: fetch wins when the starve counter equals `STARVE_MAX` and `if_req_i`=1.
- `mem_*` outputs are driven combinationally from the winner's inputs. `mem_req_o`=0 when there is no winner or the arbiter is not free.
- Grant:
  - the winner's `*_gnt_o` = `mem_req_o & mem_gnt_i`;
  - on grant, next state is OUT_IF or OUT_D, and `if_addr_i[2]` is captured into `hi_q`;
  - `mem_req_o` & !`mem_gnt_i`: the winner is re-evaluated next cycle, with no lock-in.

**Responses**
- `mem_rvalid_i` in OUT_IF → `if_rvalid_o`=1; `if_rdata_o` = `hi_q` ? `mem_rdata_i[63:32]` : `mem_rdata_i[31:0]`.
- `mem_rvalid_i` in OUT_D → `d_rvalid_o`=1; `d_rdata_o` = `mem_rdata_i`.
- After the response, state returns to IDLE unless a new grant occurs in the same cycle.
- `mem_rvalid_i` in IDLE is ignored; no output pulses.

**Starve counter**
- Increments, saturating at `STARVE_MAX`, on each free cycle with `if_req_i`=1 and fetch not granted.
- Clears on fetch grant, or on a free cycle with `if_req_i`=0.
- Width is `$clog2(STARVE_MAX+1)`.

**Other rules**
- `busy_o` = (state != IDLE).
- Simultaneous requests with the counter below `STARVE_MAX` → data granted; fetch waits.

## Timing
- Reset: state IDLE, `hi_q`=0, counter 0. While `rst`=1, every output is forced to 0.
- Reset mid-transaction drops the outstanding transaction. A late `mem_rvalid_i` after reset is ignored.
- Request-to-grant is 0 cycles when the arbiter is free and `mem_gnt_i`=1.
- Response latency equals memory latency; there is no added register stage.
- With 1-cycle memory, throughput is 1 transaction per cycle.
- No combinational path from `mem_rvalid_i` to `mem_req_o` other than via the free condition.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: starve counter and fetch override are present.
- Undefined: strict data priority, no counter; `STARVE_MAX` is unused. Fetch can then be starved indefinitely by continuous data requests.

## Structure
- Add to `riscv_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_OUT_IF, ARB_OUT_D};
  - constant `ARB_STARVE_MAX_DEFAULT` = 4.
- One sub-module, `arb_starve_ctr` (saturating counter with inc/clr/`at_max_o`). It is instantiated only under the macro.

## Test plan
- Fetch only, `if_addr_i`=0x1004, memory returns 0xAABBCCDD_11223344 next cycle → grant at cycle 0, `if_rvalid_o` at cycle 1, `if_rdata_o`=0xAABBCCDD.
- Simultaneous fetch 0x1000 and data load 0x2000 → `d_gnt_o` first, `d_rvalid_o` next cycle with `if_gnt_o` in that same cycle, fetch response one cycle later.
- Store with `d_be_i`=0x0F, `mem_gnt_i` low for 2 cycles → `mem_req_o`/`mem_we_o`/`mem_be_o` held stable 3 cycles, `d_gnt_o` on the third, `d_rvalid_o` one cycle after.
- Guard on, `STARVE_MAX`=4, continuous data requests and fetch request → data granted 4 times, fetch granted on the 5th arbitration, counter cleared.
- `rst` asserted in OUT_D, `mem_rvalid_i` arrives the cycle after release → no `d_rvalid_o`, `busy_o`=0, all outputs 0 during reset.
- Guard off, same stimulus as scenario 4 → fetch never granted over 20 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: arbiter state encoding and starvation-guard default.
// Related build macro: MEM_ARB_STARVE_GUARD_EN (consumed by mem_port_arbiter).
package riscv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OUT_IF,
    ARB_OUT_D
  } arb_state_t;

  localparam int unsigned ARB_STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive denied fetch arbitrations.
// Instantiated by mem_port_arbiter only when MEM_ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max_o
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  // Count up on each denial, hold at MAX, clear on reset or fetch progress.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_max_o = (cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and LSU data ports onto one req/gnt/rvalid memory port,
// one transaction outstanding, data priority.
// Build macro: MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [7:0]        d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  arb_state_t state, state_next;
  logic       hi_q, hi_next;
  logic       free;
  logic       at_max;
  logic       if_win, d_win, grant;

  // Free to issue when idle, or when the outstanding response lands this cycle.
  assign free = (state == ARB_IDLE) || mem_rvalid_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic ctr_inc, ctr_clr;

  assign ctr_inc = free && if_req_i && !if_gnt_o;
  assign ctr_clr = if_gnt_o || (free && !if_req_i);

  arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc     (ctr_inc),
    .clr     (ctr_clr),
    .at_max_o(at_max)
  );
`else
  // Strict data priority; STARVE_MAX is referenced only to keep it an interface parameter.
  assign at_max = 1'b0 && (STARVE_MAX != 0);
`endif

  // State and fetch-half registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      hi_q  <= 1'b0;
    end else begin
      state <= state_next;
      hi_q  <= hi_next;
    end
  end

  // Winner selection, memory-port muxing, responses and next state; all outputs held at 0 in reset.
  always_comb begin
    state_next  = state;
    hi_next     = hi_q;
    if_win      = 1'b0;
    d_win       = 1'b0;
    grant       = 1'b0;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_gnt_o     = 1'b0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    busy_o      = 1'b0;
    if (!rst) begin
      if (free) begin
        if (at_max && if_req_i) begin
          if_win = 1'b1;
        end else if (d_req_i) begin
          d_win = 1'b1;
        end else if (if_req_i) begin
          if_win = 1'b1;
        end
      end
      grant = (if_win || d_win) && mem_gnt_i;

      if (d_win) begin
        mem_req_o   = 1'b1;
        mem_we_o    = d_we_i;
        mem_be_o    = d_be_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
        d_gnt_o     = mem_gnt_i;
      end else if (if_win) begin
        mem_req_o   = 1'b1;
        mem_be_o    = '1;
        mem_addr_o  = if_addr_i;
        if_gnt_o    = mem_gnt_i;
      end

      if_rvalid_o = (state == ARB_OUT_IF) && mem_rvalid_i;
      d_rvalid_o  = (state == ARB_OUT_D) && mem_rvalid_i;
      if_rdata_o  = hi_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
      d_rdata_o   = mem_rdata_i;
      busy_o      = (state != ARB_IDLE);

      // A grant in the response cycle overrides the return to idle.
      if ((state != ARB_IDLE) && mem_rvalid_i) begin
        state_next = ARB_IDLE;
      end
      if (grant) begin
        state_next = d_win ? ARB_OUT_D : ARB_OUT_IF;
        hi_next    = if_addr_i[2];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
// Honours MEM_ARB_STARVE_GUARD_EN to select guard-on or guard-off expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [7:0]        d_be;
  logic [DATA_W-1:0] d_wdata, mem_rdata;
  logic              if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
  logic              mem_req_o, mem_we_o, busy_o;
  logic [31:0]       if_rdata_o;
  logic [DATA_W-1:0] d_rdata_o, mem_wdata_o;
  logic [7:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [238:0]      all_out;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_be_i      (d_be),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt),
    .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy_o)
  );

  assign all_out = {if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
                    mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o};

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks happen 4ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0;
    d_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    if_req = 1; d_req = 1; d_we = 1; d_be = 8'hFF; d_addr = 64'h40; d_wdata = 64'h55;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #5;
    checks++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h, expected all zero", all_out);
    if (all_out !== '0) errors++;
    next_cycle();
    rst = 0;
    idle_inputs();
    #4;
    checks++;
    if ({busy_o, mem_req_o} !== 2'b00) begin
      $display("FAIL reset_idle: busy=%0b mem_req=%0b, expected 0 0", busy_o, mem_req_o);
      errors++;
    end
  endtask

  task automatic test_fetch_single();
    apply_reset();
    if_req = 1; if_addr = 64'h1004; mem_gnt = 1;
    #4;
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 64'h1004}) begin
      $display("FAIL fetch_req: req=%0b we=%0b addr=%h, expected 1 0 1004", mem_req_o, mem_we_o, mem_addr_o);
      errors++;
    end
    checks++;
    if ({if_gnt_o, d_gnt_o} !== 2'b10) begin
      $display("FAIL fetch_gnt: if_gnt=%0b d_gnt=%0b, expected 1 0", if_gnt_o, d_gnt_o);
      errors++;
    end
    next_cycle();
    if_req = 0; mem_rvalid = 1; mem_rdata = 64'hAABBCCDD_11223344;
    #4;
    checks++;
    if ({if_rvalid_o, d_rvalid_o, busy_o} !== 3'b101) begin
      $display("FAIL fetch_rvalid: if_rvalid=%0b d_rvalid=%0b busy=%0b, expected 1 0 1", if_rvalid_o, d_rvalid_o, busy_o);
      errors++;
    end
    checks++;
    if (if_rdata_o !== 32'hAABBCCDD) begin
      $display("FAIL fetch_rdata: got %h, expected aabbccdd", if_rdata_o);
      errors++;
    end
    next_cycle();
    mem_rvalid = 0;
    #4;
    checks++;
    if ({busy_o, if_rvalid_o} !== 2'b00) begin
      $display("FAIL fetch_done: busy=%0b if_rvalid=%0b, expected 0 0", busy_o, if_rvalid_o);
      errors++;
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    if_req = 1; if_addr = 64'h1000; d_req = 1; d_we = 0; d_be = 8'hFF; d_addr = 64'h2000; mem_gnt = 1;
    #4;
    checks++;
    if ({d_gnt_o, if_gnt_o, mem_addr_o} !== {1'b1, 1'b0, 64'h2000}) begin
      $display("FAIL simul_first: d_gnt=%0b if_gnt=%0b addr=%h, expected 1 0 2000", d_gnt_o, if_gnt_o, mem_addr_o);
      errors++;
    end
    next_cycle();
    d_req = 0; mem_rvalid = 1; mem_rdata = 64'h0102030405060708;
    #4;
    checks++;
    if ({d_rvalid_o, d_rdata_o} !== {1'b1, 64'h0102030405060708}) begin
      $display("FAIL simul_dresp: d_rvalid=%0b d_rdata=%h, expected 1 0102030405060708", d_rvalid_o, d_rdata_o);
      errors++;
    end
    checks++;
    if ({if_gnt_o, if_rvalid_o, mem_addr_o} !== {1'b1, 1'b0, 64'h1000}) begin
      $display("FAIL simul_ifgnt: if_gnt=%0b if_rvalid=%0b addr=%h, expected 1 0 1000", if_gnt_o, if_rvalid_o, mem_addr_o);
      errors++;
    end
    next_cycle();
    if_req = 0; mem_rdata = 64'h99887766_CAFEF00D;
    #4;
    checks++;
    if ({if_rvalid_o, d_rvalid_o, if_rdata_o} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      $display("FAIL simul_ifresp: if_rvalid=%0b d_rvalid=%0b if_rdata=%h, expected 1 0 cafef00d", if_rvalid_o, d_rvalid_o, if_rdata_o);
      errors++;
    end
    next_cycle();
    mem_rvalid = 0;
  endtask

  task automatic test_store_wait();
    apply_reset();
    d_req = 1; d_we = 1; d_be = 8'h0F; d_addr = 64'h3008; d_wdata = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 3; i++) begin
      mem_gnt = (i == 2);
      #4;
      checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 8'h0F, 64'h3008, 64'h0123_4567_89AB_CDEF}) begin
        $display("FAIL store_hold[%0d]: req=%0b we=%0b be=%h addr=%h wdata=%h, expected 1 1 0f 3008 0123456789abcdef",
                 i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        errors++;
      end
      checks++;
      if (d_gnt_o !== (i == 2)) begin
        $display("FAIL store_gnt[%0d]: got %0b, expected %0b", i, d_gnt_o, (i == 2));
        errors++;
      end
      next_cycle();
    end
    d_req = 0; mem_gnt = 0; mem_rvalid = 1;
    #4;
    checks++;
    if ({d_rvalid_o, busy_o} !== 2'b11) begin
      $display("FAIL store_resp: d_rvalid=%0b busy=%0b, expected 1 1", d_rvalid_o, busy_o);
      errors++;
    end
    next_cycle();
    mem_rvalid = 0;
    #4;
    checks++;
    if (busy_o !== 1'b0) begin
      $display("FAIL store_done: busy=%0b, expected 0", busy_o);
      errors++;
    end
  endtask

  task automatic test_starve();
    int first_if, second_if, ig, dg;
    first_if = -1; second_if = -1; ig = 0; dg = 0;
    apply_reset();
    d_req = 1; d_we = 0; d_be = 8'hFF; d_addr = 64'h2000;
    if_req = 1; if_addr = 64'h1000; mem_gnt = 1;
    for (int i = 0; i < 20; i++) begin
      #4;
      if (if_gnt_o === 1'b1) begin
        ig++;
        if (first_if < 0) first_if = i;
        else if (second_if < 0) second_if = i;
      end
      if (d_gnt_o === 1'b1) dg++;
      next_cycle();
      mem_rvalid = 1;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    checks++;
    if (first_if != 4) begin
      $display("FAIL starve_first: fetch first granted at arbitration %0d, expected 4", first_if);
      errors++;
    end
    checks++;
    if (second_if != 9) begin
      $display("FAIL starve_clear: fetch second granted at arbitration %0d, expected 9", second_if);
      errors++;
    end
    checks++;
    if (ig + dg != 20) begin
      $display("FAIL starve_total: %0d grants, expected 20", ig + dg);
      errors++;
    end
`else
    checks++;
    if (ig != 0) begin
      $display("FAIL starve_off: fetch granted %0d times (first at %0d), expected 0", ig, first_if);
      errors++;
    end
    checks++;
    if (dg != 20) begin
      $display("FAIL starve_off_data: data granted %0d times, expected 20", dg);
      errors++;
    end
`endif
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    d_req = 1; d_we = 0; d_be = 8'hFF; d_addr = 64'h2000; mem_gnt = 1;
    #4;
    checks++;
    if (d_gnt_o !== 1'b1) begin
      $display("FAIL rstmid_gnt: d_gnt=%0b, expected 1", d_gnt_o);
      errors++;
    end
    next_cycle();
    rst = 1; if_req = 1; mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_1234_5678;
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++;
      if (all_out !== '0) begin
        $display("FAIL rstmid_outputs[%0d]: got %h, expected all zero", i, all_out);
        errors++;
      end
      next_cycle();
    end
    rst = 0;
    idle_inputs();
    mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_1234_5678;
    #4;
    checks++;
    if ({d_rvalid_o, if_rvalid_o, busy_o, mem_req_o} !== 4'b0000) begin
      $display("FAIL rstmid_late: d_rvalid=%0b if_rvalid=%0b busy=%0b mem_req=%0b, expected 0 0 0 0",
               d_rvalid_o, if_rvalid_o, busy_o, mem_req_o);
      errors++;
    end
    next_cycle();
    mem_rvalid = 0;
  endtask

  // Reference model: one outstanding transaction tracked as "who is waiting for a response",
  // memory modelled as a random grant plus a random 1..3-cycle response delay.
  task automatic test_random();
    int  pending;   // 0 none, 1 fetch, 2 data
    bit  hi;
    int  starve;
    int  lat;
    int  win;
    bit  free, force_if, e_gnt, drop_if, drop_d, e_ifrv, e_drv;
    logic [31:0] e_ifdata;
    pending = 0; hi = 0; starve = 0; lat = 0; drop_if = 0; drop_d = 0;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      if (drop_if) if_req = 0;
      if (drop_d) d_req = 0;
      drop_if = 0; drop_d = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = {$urandom, $urandom} & ~64'h3;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 8'($urandom);
        d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
      end
      mem_gnt    = ($urandom_range(0, 3) != 0);
      mem_rvalid = (lat == 1) || (lat == 0 && $urandom_range(0, 7) == 0);
      mem_rdata  = {$urandom, $urandom};
      #4;

      free = (pending == 0) || mem_rvalid;
      force_if = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      force_if = (starve == STARVE_MAX) && if_req;
`endif
      win = 0;
      if (free) begin
        if (force_if) win = 1;
        else if (d_req) win = 2;
        else if (if_req) win = 1;
      end
      e_gnt    = (win != 0) && mem_gnt;
      e_ifrv   = (pending == 1) && mem_rvalid;
      e_drv    = (pending == 2) && mem_rvalid;
      e_ifdata = hi ? mem_rdata[63:32] : mem_rdata[31:0];

      checks++;
      if (mem_req_o !== (win != 0)) begin
        $display("FAIL rnd_req@%0d: got %0b, expected %0b", n, mem_req_o, (win != 0));
        errors++;
      end
      if (win == 2) begin
        checks++;
        if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {d_we, d_be, d_addr, d_wdata}) begin
          $display("FAIL rnd_dport@%0d: we=%0b be=%h addr=%h wdata=%h, expected %0b %h %h %h",
                   n, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, d_we, d_be, d_addr, d_wdata);
          errors++;
        end
      end
      if (win == 1) begin
        checks++;
        if ({mem_we_o, mem_addr_o} !== {1'b0, if_addr}) begin
          $display("FAIL rnd_ifport@%0d: we=%0b addr=%h, expected 0 %h", n, mem_we_o, mem_addr_o, if_addr);
          errors++;
        end
      end
      checks++;
      if ({if_gnt_o, d_gnt_o} !== {(win == 1) && e_gnt, (win == 2) && e_gnt}) begin
        $display("FAIL rnd_gnt@%0d: if_gnt=%0b d_gnt=%0b, expected %0b %0b",
                 n, if_gnt_o, d_gnt_o, (win == 1) && e_gnt, (win == 2) && e_gnt);
        errors++;
      end
      checks++;
      if ({if_rvalid_o, d_rvalid_o, busy_o} !== {e_ifrv, e_drv, pending != 0}) begin
        $display("FAIL rnd_resp@%0d: if_rvalid=%0b d_rvalid=%0b busy=%0b, expected %0b %0b %0b",
                 n, if_rvalid_o, d_rvalid_o, busy_o, e_ifrv, e_drv, pending != 0);
        errors++;
      end
      if (e_ifrv) begin
        checks++;
        if (if_rdata_o !== e_ifdata) begin
          $display("FAIL rnd_ifdata@%0d: got %h, expected %h", n, if_rdata_o, e_ifdata);
          errors++;
        end
      end
      if (e_drv) begin
        checks++;
        if (d_rdata_o !== mem_rdata) begin
          $display("FAIL rnd_ddata@%0d: got %h, expected %h", n, d_rdata_o, mem_rdata);
          errors++;
        end
      end

      if (free) begin
        if (if_req && !(win == 1 && e_gnt)) starve = (starve < int'(STARVE_MAX)) ? starve + 1 : int'(STARVE_MAX);
        else starve = 0;
      end
      if (lat > 0) lat--;
      if (e_gnt) begin
        pending = win;
        lat = $urandom_range(1, 3);
        if (win == 1) begin
          hi = if_addr[2];
          drop_if = 1;
        end else begin
          drop_d = 1;
        end
      end else if (pending != 0 && mem_rvalid) begin
        pending = 0;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch_single();
    test_simultaneous();
    test_store_wait();
    test_starve();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
